// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: controller state encoding and BCD digit widths.
package timer_pkg;

  localparam int TENS_W = 3;
  localparam int ONES_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/btn_pulse.sv
// Rising-edge detector for a debounced button level: one single-cycle pulse per press,
// however long the button is held.
module btn_pulse
  import timer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

  assign pulse = btn & ~btn_q;

endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/done sequencer for the two-digit BCD countdown datapath, with 1 Hz tick prescaler.
// Optional macro TIMER_CTRL_DONE_BLINK_EN makes done_led blink in DONE instead of staying solid.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV  = 100000000,
  parameter int INIT_TENS = 3,
  parameter int INIT_ONES = 0,
  parameter int LED_W     = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_ss,
  input  logic             btn_clr,
  input  logic             cnt_zero,
  output logic             count_en,
  output logic             load,
  output logic [2:0]       load_tens,
  output logic [3:0]       load_ones,
  output logic [1:0]       state,
  output logic             stateled,
  output logic [LED_W-1:0] done_led
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  state_t        cur_state;
  state_t        next_state;
  logic          ss_p;
  logic          clr_p;
  logic [PW-1:0] presc;

  btn_pulse u_ss_pulse (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_ss),
    .pulse (ss_p)
  );

  btn_pulse u_clr_pulse (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .pulse (clr_p)
  );

  // Clear overrides everything, so a simultaneous start/stop press is simply dropped.
  always_comb begin
    next_state = cur_state;
    if (clr_p) begin
      next_state = IDLE;
    end else begin
      case (cur_state)
        IDLE:    if (ss_p) next_state = RUN;
        RUN: begin
          if (cnt_zero)  next_state = DONE;
          else if (ss_p) next_state = PAUSE;
        end
        PAUSE:   if (ss_p) next_state = RUN;
        DONE:    if (ss_p) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Prescaler only advances in RUN, so a pause resumes the partial tick where it left off.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      presc <= '0;
    end else if (next_state == IDLE) begin
      presc <= '0;
    end else if (cur_state == RUN) begin
      presc <= (presc == PRE_MAX) ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      load <= 1'b0;
    end else begin
      load <= clr_p | ((cur_state == DONE) & ss_p);
    end
  end

  // Gating on cnt_zero keeps the datapath from wrapping below 00 on the final tick.
  assign count_en  = (cur_state == RUN) && (presc == PRE_MAX) && !cnt_zero;
  assign load_tens = TENS_W'(INIT_TENS);
  assign load_ones = ONES_W'(INIT_ONES);
  assign state     = cur_state;
  assign stateled  = (cur_state == RUN);

`ifdef TIMER_CTRL_DONE_BLINK_EN
  localparam logic [PW-1:0] HALF_MAX = PW'((TICK_DIV / 2) - 1);

  logic [PW-1:0] blink_cnt;
  logic          blink_off;

  // Counter sits at zero outside DONE, so every DONE visit starts with the LEDs lit.
  always_ff @(posedge clk) begin
    if (rst_n || (cur_state != DONE)) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == HALF_MAX) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign done_led = ((cur_state == DONE) && !blink_off) ? '1 : '0;
`else
  assign done_led = (cur_state == DONE) ? '1 : '0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: a directed walk through the main scenarios, then random button
// traffic, all predicted by a cycle-level reference model driving a small BCD datapath model.
module tb_timer_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int INIT_TENS = 3;
  localparam int INIT_ONES = 0;
  localparam int LED_W     = 15;
  localparam int PRESET    = INIT_TENS * 10 + INIT_ONES;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             btn_ss;
  logic             btn_clr;
  logic             cnt_zero;
  logic             count_en;
  logic             load;
  logic [2:0]       load_tens;
  logic [3:0]       load_ones;
  logic [1:0]       state;
  logic             stateled;
  logic [LED_W-1:0] done_led;

  typedef struct {
    logic [1:0]       st;
    logic             ce;
    logic             ld;
    logic             led;
    logic [LED_W-1:0] dled;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   tests = 0;
  int   fails = 0;

  int m_mode;
  int m_phase;
  int m_done_cyc;
  int dp_val;
  bit m_load;
  bit m_prev_ss;
  bit m_prev_clr;

  always #5 clk = ~clk;

  timer_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .INIT_TENS (INIT_TENS),
    .INIT_ONES (INIT_ONES),
    .LED_W     (LED_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_ss    (btn_ss),
    .btn_clr   (btn_clr),
    .cnt_zero  (cnt_zero),
    .count_en  (count_en),
    .load      (load),
    .load_tens (load_tens),
    .load_ones (load_ones),
    .state     (state),
    .stateled  (stateled),
    .done_led  (done_led)
  );

  function automatic bit blinkOn(input int cyc);
`ifdef TIMER_CTRL_DONE_BLINK_EN
    return ((cyc / (TICK_DIV / 2)) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    m_mode     = M_IDLE;
    m_phase    = 0;
    m_done_cyc = 0;
    m_load     = 1'b0;
    m_prev_ss  = 1'b0;
    m_prev_clr = 1'b0;
  endtask

  task automatic applyStimulus(input bit ss, input bit clr, input bit rst, input bit force_zero);
    exp_t e;
    bit   cz;
    bit   ssp;
    bit   clrp;
    int   nmode;
    @(posedge clk);
    #2;
    cz       = (dp_val == 0) || force_zero;
    btn_ss   = ss;
    btn_clr  = clr;
    rst_n    = rst;
    cnt_zero = cz;
    e.st   = 2'(m_mode);
    e.ce   = (m_mode == M_RUN) && (m_phase == TICK_DIV - 1) && !cz;
    e.ld   = m_load;
    e.led  = (m_mode == M_RUN);
    e.dled = ((m_mode == M_DONE) && blinkOn(m_done_cyc)) ? '1 : '0;
    sb.push_back(e);
    if (m_load) dp_val = PRESET;
    else if (e.ce && dp_val > 0) dp_val = dp_val - 1;
    if (rst) begin
      modelReset();
    end else begin
      ssp        = ss && !m_prev_ss;
      clrp       = clr && !m_prev_clr;
      m_prev_ss  = ss;
      m_prev_clr = clr;
      m_load     = clrp || (m_mode == M_DONE && ssp);
      nmode      = m_mode;
      if (clrp) nmode = M_IDLE;
      else if (m_mode == M_IDLE && ssp) nmode = M_RUN;
      else if (m_mode == M_RUN && cz) nmode = M_DONE;
      else if (m_mode == M_RUN && ssp) nmode = M_PAUSE;
      else if (m_mode == M_PAUSE && ssp) nmode = M_RUN;
      else if (m_mode == M_DONE && ssp) nmode = M_IDLE;
      if (m_mode == M_RUN) m_phase = (m_phase + 1) % TICK_DIV;
      if (nmode == M_IDLE) m_phase = 0;
      m_done_cyc = (m_mode == M_DONE && nmode == M_DONE) ? m_done_cyc + 1 : 0;
      m_mode = nmode;
    end
  endtask

  // Monitor: every queued expectation is matched against the outputs of that cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        checkOutput("state", 32'(state), 32'(got.st));
        checkOutput("count_en", 32'(count_en), 32'(got.ce));
        checkOutput("load", 32'(load), 32'(got.ld));
        checkOutput("stateled", 32'(stateled), 32'(got.led));
        checkOutput("done_led", 32'(done_led), 32'(got.dled));
        checkOutput("load_tens", 32'(load_tens), 32'(INIT_TENS));
        checkOutput("load_ones", 32'(load_ones), 32'(INIT_ONES));
      end
    end
  end

  initial begin
    int ss_l;
    int clr_l;
    bit fz;
    rst_n    = 1'b1;
    btn_ss   = 1'b0;
    btn_clr  = 1'b0;
    cnt_zero = 1'b0;
    dp_val   = 2;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    modelReset();

    // Reset state, then a clear press loads the preset
    repeat (2) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);

    // Held start/stop: one RUN entry, ticks every TICK_DIV cycles
    repeat (20) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Pause and resume mid-tick
    applyStimulus(1, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    repeat (5) applyStimulus(0, 0, 0, 0);

    // Countdown end landing on the tick cycle
    for (int i = 0; i < 12; i++) begin
      fz = (m_mode == M_RUN) && (m_phase == TICK_DIV - 1);
      applyStimulus(0, 0, 0, fz);
      if (m_mode == M_DONE) break;
    end
    repeat (6) applyStimulus(0, 0, 0, 0);

    // Leave DONE, restart from a clean prescaler
    applyStimulus(1, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);

    // Clear and start/stop rising together while running
    applyStimulus(1, 1, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);

    // Reset in the middle of a run
    applyStimulus(1, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    repeat (6) applyStimulus(0, 0, 0, 0);

    ss_l  = 0;
    clr_l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) ss_l = 1 - ss_l;
      if ($urandom_range(0, 199) == 0) clr_l = 1 - clr_l;
      applyStimulus(ss_l[0], clr_l[0], $urandom_range(0, 599) == 0, $urandom_range(0, 99) == 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
